// File: rtl/mb_fetch_stream.sv
// Streaming macroblock fetcher: reads an SxS block from frame memory
// with edge replication and emits it as a raster beat stream.
module mb_fetch_stream #(
  parameter int PIX_W        = 8,
  parameter int FRAME_W      = 1280,
  parameter int FRAME_H      = 720,
  parameter int MB_SIZE      = 16,
  parameter int PIX_PER_BEAT = 4,
  parameter int ADDR_W       = 18,
  parameter int MEM_LAT      = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [15:0]                   req_x,
  input  logic [15:0]                   req_y,
  input  logic [1:0]                    req_size,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [PIX_W*PIX_PER_BEAT-1:0] mem_rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PIX_W*PIX_PER_BEAT-1:0] out_data,
  output logic                          out_last
);

  localparam int BW     = PIX_W * PIX_PER_BEAT;
  localparam int DEPTH  = MEM_LAT + 2;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int PPB_LG = $clog2(PIX_PER_BEAT);
  localparam int MB_LG  = $clog2(MB_SIZE);
  localparam int WPR    = FRAME_W / PIX_PER_BEAT;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t            state_q;
  logic              req_ready_q;
  logic              mem_rd_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              rd_rep_q;
  logic              rd_last_q;
  logic [15:0]       x0_q;
  logic [15:0]       y0_q;
  logic [2:0]        lg_q;
  logic [4:0]        r_q;
  logic [4:0]        c_q;

  logic [MEM_LAT-1:0] pv_q;
  logic [MEM_LAT-1:0] prep_q;
  logic [MEM_LAT-1:0] plast_q;

  logic [BW:0]   fmem_q [DEPTH];
  logic [PW-1:0] wp_q;
  logic [PW-1:0] rp_q;
  logic [CW-1:0] fcnt_q;
  logic [CW-1:0] cr_q;

  // Size code -> log2 edge, clamped to [log2(PPB), log2(MB_SIZE)]
  logic [2:0]  lg_req;
  logic [15:0] msk;
  logic [4:0]  bm1_req;
  logic [4:0]  bm1_cur;
  logic [4:0]  s_m1;

  always_comb begin
    lg_req = 3'(req_size) + 3'd2;
    if (lg_req > 3'(MB_LG)) lg_req = 3'(MB_LG);
    if (lg_req < 3'(PPB_LG)) lg_req = 3'(PPB_LG);
  end

  assign msk     = 16'hFFFF << lg_req;
  assign bm1_req = 5'((32'd1 << (lg_req - 3'(PPB_LG))) - 32'd1);
  assign bm1_cur = 5'((32'd1 << (lg_q - 3'(PPB_LG))) - 32'd1);
  assign s_m1    = 5'((32'd1 << lg_q) - 32'd1);

  logic accept;
  logic pop;
  logic credit_ok;
  logic issue;
  logic is_last_rd;

  assign accept     = (state_q == IDLE) & req_valid;
  assign pop        = out_valid & out_ready;
  assign credit_ok  = (cr_q < CW'(DEPTH)) | pop;
  assign issue      = accept | ((state_q == FETCH) & credit_ok);
  assign is_last_rd = (state_q == FETCH) & (r_q == s_m1)
                    & (c_q == bm1_cur);

  // Coordinates of the read issued this cycle
  logic [15:0]       bx;
  logic [15:0]       by;
  logic [4:0]        br;
  logic [4:0]        bc;
  logic [4:0]        bm1;
  logic [4:0]        nr;
  logic [4:0]        nc;
  logic [16:0]       px;
  logic [16:0]       ry_raw;
  logic [16:0]       ry;
  logic [16:0]       word;
  logic              rep;
  logic [ADDR_W-1:0] addr;

  always_comb begin
    bx  = accept ? (req_x & msk) : x0_q;
    by  = accept ? (req_y & msk) : y0_q;
    br  = accept ? 5'd0 : r_q;
    bc  = accept ? 5'd0 : c_q;
    bm1 = accept ? bm1_req : bm1_cur;
    if (bc == bm1) begin
      nr = br + 5'd1;
      nc = 5'd0;
    end else begin
      nr = br;
      nc = bc + 5'd1;
    end
    px     = {1'b0, bx} + (17'(bc) << PPB_LG);
    ry_raw = {1'b0, by} + 17'(br);
    ry     = (ry_raw > 17'(FRAME_H - 1)) ? 17'(FRAME_H - 1) : ry_raw;
    rep    = px > 17'(FRAME_W - PIX_PER_BEAT);
    word   = rep ? 17'(WPR - 1) : (px >> PPB_LG);
    addr   = ADDR_W'(ry) * ADDR_W'(WPR) + ADDR_W'(word);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      rd_rep_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      x0_q        <= '0;
      y0_q        <= '0;
      lg_q        <= '0;
      r_q         <= '0;
      c_q         <= '0;
    end else begin
      mem_rd_en_q <= issue;
      rd_rep_q    <= rep;
      rd_last_q   <= issue & is_last_rd;
      if (issue) mem_addr_q <= addr;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            x0_q        <= req_x & msk;
            y0_q        <= req_y & msk;
            lg_q        <= lg_req;
            r_q         <= nr;
            c_q         <= nc;
            req_ready_q <= 1'b0;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          if (credit_ok) begin
            r_q <= nr;
            c_q <= nc;
            if (is_last_rd) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop & out_last) begin
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tags ride alongside the read so they meet the data on return
  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q    <= '0;
      prep_q  <= '0;
      plast_q <= '0;
    end else begin
      pv_q[0]    <= mem_rd_en_q;
      prep_q[0]  <= rd_rep_q;
      plast_q[0] <= rd_last_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        pv_q[i]    <= pv_q[i-1];
        prep_q[i]  <= prep_q[i-1];
        plast_q[i] <= plast_q[i-1];
      end
    end
  end

  logic          push;
  logic [BW-1:0] ret_data;

  assign push     = pv_q[MEM_LAT-1];
  assign ret_data = prep_q[MEM_LAT-1]
                  ? {PIX_PER_BEAT{mem_rd_data[BW-1 -: PIX_W]}}
                  : mem_rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fmem_q[i] <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
      cr_q   <= '0;
    end else begin
      if (push) begin
        fmem_q[wp_q] <= {plast_q[MEM_LAT-1], ret_data};
        wp_q <= (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
      end
      if (pop) begin
        rp_q <= (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + 1'b1;
      end
      fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
      cr_q   <= cr_q + CW'(issue) - CW'(pop);
    end
  end

  logic [BW:0] head;

  assign head      = fmem_q[rp_q];
  assign out_valid = (fcnt_q != '0);
  assign out_data  = head[BW-1:0];
  assign out_last  = head[BW] & out_valid;
  assign req_ready = req_ready_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;

endmodule
